// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier control unit:
// FSM state encoding, default width and the {q0,qsub1} pair codes.
package booth_pkg;

    // Binary-encoded controller states
    typedef enum logic [2:0] {
        ESPERA   = 3'd0,
        CARGA    = 3'd1,
        EVALUA   = 3'd2,
        DESPLAZA = 3'd3,
        FIN      = 3'd4
    } estado_e;

    // Default multiplier width / iteration count
    localparam int N_DEF = 3;

    // Booth recoding pairs {q0, qsub1}
    localparam logic [1:0] PAR_SUMA  = 2'b01;  // end of a run of ones: A + M
    localparam logic [1:0] PAR_RESTA = 2'b10;  // start of a run of ones: A - M

endpackage

// File: rtl/contador_iter.sv
// Loadable iteration down-counter. Reloads to N, counts down once per
// shift and flags the last iteration (count == 1). Holds at zero, never wraps.
module contador_iter #(
    parameter int N  = 3,
    parameter int CW = $clog2(N+1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic carga_i,
    input  logic dec_i,
    output logic ultimo_o
);

    logic [CW-1:0] cnt_q;

    // Count register: reload on carga_i, decrement on dec_i
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= CW'(N);
        else if (carga_i)
            cnt_q <= CW'(N);
        else if (dec_i && (cnt_q != '0))
            cnt_q <= cnt_q - 1'b1;
    end

    assign ultimo_o = (cnt_q == CW'(1));

endmodule

// File: rtl/unidad_control_booth.sv
// Radix-2 Booth multiplier controller: load, N evaluate/shift iterations,
// then hold the result valid until the start request is released.
module unidad_control_booth
    import booth_pkg::*;
#(
    parameter int  N  = N_DEF,
    localparam int CW = $clog2(N+1)
) (
    input  logic clk,
    input  logic reset,
    input  logic comenzar,
    input  logic q0,
    input  logic qsub1,
    output logic CargaA,
    output logic CargaQ,
    output logic CargaM,
    output logic desplaza,
    output logic resta,
    output logic limpia,
    output logic ocupado,
    output logic fin
);

    estado_e state_q, state_d;
    logic    ultimo;

    contador_iter #(.N(N), .CW(CW)) u_contador (
        .clk      (clk),
        .rst_n    (reset),
        .carga_i  (state_q == CARGA),
        .dec_i    (state_q == DESPLAZA),
        .ultimo_o (ultimo)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= ESPERA;
        else
            state_q <= state_d;
    end

    // Next-state and strobe decode; q0/qsub1 only matter in EVALUA
    always_comb begin
        state_d  = state_q;
        CargaA   = 1'b0;
        CargaQ   = 1'b0;
        CargaM   = 1'b0;
        desplaza = 1'b0;
        resta    = 1'b0;
        limpia   = 1'b0;
        ocupado  = 1'b0;
        fin      = 1'b0;
        unique case (state_q)
            ESPERA: begin
                if (comenzar) state_d = CARGA;
            end
            CARGA: begin
                CargaQ  = 1'b1;
                CargaM  = 1'b1;
                limpia  = 1'b1;
                ocupado = 1'b1;
                state_d = EVALUA;
            end
            EVALUA: begin
                ocupado = 1'b1;
                case ({q0, qsub1})
                    PAR_RESTA: begin
                        CargaA = 1'b1;
                        resta  = 1'b1;
                    end
                    PAR_SUMA: CargaA = 1'b1;
                    default:  ;
                endcase
                state_d = DESPLAZA;
            end
            DESPLAZA: begin
                desplaza = 1'b1;
                ocupado  = 1'b1;
                state_d  = ultimo ? FIN : EVALUA;
            end
            FIN: begin
                fin = 1'b1;
                if (!comenzar) state_d = ESPERA;
            end
            default: state_d = ESPERA;
        endcase
    end

endmodule

// File: tb/tb_unidad_control_booth.sv
// Directed bench for the Booth control unit: strobe sequences for several
// recoding patterns, async reset mid-operation, handshake, start-glitch
// immunity, an N=1 build and an end-to-end product through a datapath model.
module tb_unidad_control_booth;

    logic clk = 1'b0;
    logic reset, comenzar, q0_drv, qsub1_drv, modo_dp;
    logic q0, qsub1;
    logic CargaA, CargaQ, CargaM, desplaza, resta, limpia, ocupado, fin;
    logic c1, q01, qs11;
    logic a1, cq1, cm1, d1, r1, l1, o1, f1;
    logic [7:0] outs, outs1;
    int checks = 0;
    int errors = 0;

    // Output vector bit order: CargaA CargaQ CargaM desplaza resta limpia ocupado fin
    localparam logic [7:0] O_IDLE   = 8'b0000_0000;
    localparam logic [7:0] O_CARGA  = 8'b0110_0110;
    localparam logic [7:0] O_NONE   = 8'b0000_0010;
    localparam logic [7:0] O_RESTA  = 8'b1000_1010;
    localparam logic [7:0] O_SUMA   = 8'b1000_0010;
    localparam logic [7:0] O_DESPL  = 8'b0001_0010;
    localparam logic [7:0] O_FIN    = 8'b0000_0001;

    always #5 clk = ~clk;

    // Bench-side 3-bit Booth datapath (A, Q, Q-1, M)
    logic [2:0] ma, mq, mm;
    logic       mqm1;
    always @(posedge clk) begin
        if (CargaM) mm <= 3'd3;
        if (CargaQ) mq <= 3'b110;
        if (limpia) begin
            ma   <= 3'd0;
            mqm1 <= 1'b0;
        end else if (CargaA) begin
            ma <= resta ? ma - mm : ma + mm;
        end else if (desplaza) begin
            ma   <= {ma[2], ma[2:1]};
            mq   <= {ma[0], mq[2:1]};
            mqm1 <= mq[0];
        end
    end

    assign q0    = modo_dp ? mq[0] : q0_drv;
    assign qsub1 = modo_dp ? mqm1  : qsub1_drv;

    unidad_control_booth #(.N(3)) dut (
        .clk(clk), .reset(reset), .comenzar(comenzar), .q0(q0), .qsub1(qsub1),
        .CargaA(CargaA), .CargaQ(CargaQ), .CargaM(CargaM), .desplaza(desplaza),
        .resta(resta), .limpia(limpia), .ocupado(ocupado), .fin(fin)
    );

    unidad_control_booth #(.N(1)) dut1 (
        .clk(clk), .reset(reset), .comenzar(c1), .q0(q01), .qsub1(qs11),
        .CargaA(a1), .CargaQ(cq1), .CargaM(cm1), .desplaza(d1),
        .resta(r1), .limpia(l1), .ocupado(o1), .fin(f1)
    );

    assign outs  = {CargaA, CargaQ, CargaM, desplaza, resta, limpia, ocupado, fin};
    assign outs1 = {a1, cq1, cm1, d1, r1, l1, o1, f1};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %b exp %b", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_eval(input logic [1:0] p);
        case (p)
            2'b10:   return O_RESTA;
            2'b01:   return O_SUMA;
            default: return O_NONE;
        endcase
    endfunction

    // Full sequence from ESPERA with comenzar=1 already applied
    task automatic run_seq(input string tag, input logic [5:0] pares, input bit toggle);
        logic [1:0] p;
        tick();
        chk({tag, "_carga"}, outs, O_CARGA);
        for (int i = 0; i < 3; i++) begin
            p = pares[5-2*i -: 2];
            tick();
            if (toggle) comenzar = ~comenzar;
            {q0_drv, qsub1_drv} = p;
            #1;
            chk($sformatf("%s_eval%0d", tag, i), outs, exp_eval(p));
            tick();
            {q0_drv, qsub1_drv} = ~p;  // pair must be ignored outside EVALUA
            if (toggle) comenzar = ~comenzar;
            #1;
            chk($sformatf("%s_despl%0d", tag, i), outs, O_DESPL);
        end
        tick();
        chk({tag, "_fin"}, outs, O_FIN);
    endtask

    initial begin
        int cyc;
        reset = 1'b0; comenzar = 1'b0; q0_drv = 1'b0; qsub1_drv = 1'b0; modo_dp = 1'b0;
        c1 = 1'b0; q01 = 1'b0; qs11 = 1'b0;
        #2;
        chk("reset_state", outs, O_IDLE);
        chk("reset_state_n1", outs1, O_IDLE);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        tick();
        chk("idle", outs, O_IDLE);

        // Q=110: pairs 00,10,11; fin after 8 edges
        comenzar = 1'b1;
        run_seq("q110", 6'b00_10_11, 1'b0);

        // Handshake: hold in FIN, drop -> ESPERA, reassert -> CARGA
        tick();
        chk("fin_hold", outs, O_FIN);
        comenzar = 1'b0;
        tick();
        chk("fin_release", outs, O_IDLE);
        comenzar = 1'b1;
        tick();
        chk("restart_carga", outs, O_CARGA);

        // Async reset in the middle of EVALUA
        tick();
        {q0_drv, qsub1_drv} = 2'b10;
        #1;
        chk("pre_reset_eval", outs, O_RESTA);
        reset = 1'b0;
        #1;
        chk("reset_mid", outs, O_IDLE);
        tick();
        @(negedge clk);
        reset = 1'b1;
        comenzar = 1'b0;
        tick();
        chk("post_reset_idle", outs, O_IDLE);

        // Q=011: pairs 10,11,01
        comenzar = 1'b1;
        run_seq("q011", 6'b10_11_01, 1'b0);
        comenzar = 1'b0;
        tick();
        chk("q011_release", outs, O_IDLE);

        // comenzar toggled while busy
        comenzar = 1'b1;
        run_seq("toggle", 6'b00_10_11, 1'b1);
        comenzar = 1'b0;
        tick();
        chk("toggle_release", outs, O_IDLE);

        // End to end: M=3, Q=-2 -> {A,Q} = -6
        modo_dp = 1'b1;
        comenzar = 1'b1;
        cyc = 0;
        while (fin !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("dp_latency", 8'(cyc), 8'd8);
        chk("dp_product", {2'b00, ma, mq}, {2'b00, 6'b111010});
        comenzar = 1'b0;
        modo_dp = 1'b0;
        tick();
        chk("dp_release", outs, O_IDLE);

        // N=1 build: CARGA, EVALUA, DESPLAZA, FIN at edge 4
        c1 = 1'b1;
        tick();
        chk("n1_carga", outs1, O_CARGA);
        tick();
        {q01, qs11} = 2'b01;
        #1;
        chk("n1_eval", outs1, O_SUMA);
        tick();
        chk("n1_despl", outs1, O_DESPL);
        tick();
        chk("n1_fin", outs1, O_FIN);
        c1 = 1'b0;
        tick();
        chk("n1_release", outs1, O_IDLE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
